// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side signals of the shared memory port
interface mem_port_arbiter_if;
  logic        i_rd;
  logic [15:0] i_addr;
  logic [15:0] i_data;
  logic        i_done;
  logic        i_stall;
  logic        d_rd;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_data;
  logic        d_done;
  logic        d_stall;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic        m_rd;
  logic        m_wr;
  logic [15:0] m_dout;
  logic        m_done;
  logic        m_stall;
  logic        m_err;
  logic        err;
  modport master (
    input  i_rd, i_addr, d_rd, d_wr, d_addr, d_wdata, m_dout, m_done, m_stall, m_err,
    output i_data, i_done, i_stall, d_data, d_done, d_stall, m_addr, m_wdata, m_rd, m_wr, err
  );
  modport slave (
    output i_rd, i_addr, d_rd, d_wr, d_addr, d_wdata, m_dout, m_done, m_stall, m_err,
    input  i_data, i_done, i_stall, d_data, d_done, d_stall, m_addr, m_wdata, m_rd, m_wr, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one multi-cycle memory port between fetch and data stages
module mem_port_arbiter #(
  parameter int WATCHDOG = 64
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam logic [7:0] WD = 8'(WATCHDOG);
  state_t state, state_nxt;
  logic owner, last, rd, wr;
  logic [15:0] addr, wdata;
  logic [7:0] cnt;
  logic i_req, d_req, grant, grant_d, busy, timeout, to_done;
  assign i_req = bus.i_rd;
  assign d_req = bus.d_rd | bus.d_wr;
  assign grant = i_req | d_req;
  assign grant_d = d_req & (~i_req | ~last);
  assign busy = state == ISSUE || state == WAIT;
  assign timeout = state == WAIT && cnt + 8'd1 == WD;
  assign to_done = busy && (bus.m_done || timeout);
  always_comb begin
    state_nxt = to_done ? DONE : state == IDLE ? (grant ? ISSUE : IDLE) : state == DONE ? IDLE : WAIT;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner <= 1'b0;
      last <= 1'b0;
      rd <= 1'b0;
      wr <= 1'b0;
      addr <= 16'h0000;
      wdata <= 16'h0000;
      cnt <= 8'd0;
      bus.i_data <= 16'h0000;
      bus.d_data <= 16'h0000;
      bus.err <= 1'b0;
    end else begin
      if (state == IDLE && grant) begin
        owner <= grant_d;
        last <= grant_d;
        addr <= grant_d ? bus.d_addr : bus.i_addr;
        wdata <= bus.d_wdata;
        rd <= ~grant_d | ~bus.d_wr;
        wr <= grant_d & bus.d_wr;
      end
      cnt <= state == WAIT ? cnt + 8'd1 : 8'd0;
      if (to_done && rd && !owner) bus.i_data <= bus.m_done ? bus.m_dout : 16'h0000;
      if (to_done && rd && owner) bus.d_data <= bus.m_done ? bus.m_dout : 16'h0000;
      if ((state == IDLE && grant_d && bus.d_rd && bus.d_wr) || (busy && bus.m_err) || (timeout && !bus.m_done)) bus.err <= 1'b1;
    end
  end
  assign bus.m_rd = state == ISSUE && rd;
  assign bus.m_wr = state == ISSUE && wr;
  assign bus.m_addr = busy ? addr : 16'h0000;
  assign bus.m_wdata = busy ? wdata : 16'h0000;
  assign bus.i_done = state == DONE && !owner;
  assign bus.d_done = state == DONE && owner;
  assign bus.i_stall = bus.i_rd & ~bus.i_done;
  assign bus.d_stall = (bus.d_rd | bus.d_wr) & ~bus.d_done;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors, corner sequences and randomized rounds against a transaction-level model
module tb_mem_port_arbiter;
  localparam int WD = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mem_port_arbiter_if bus();
  mem_port_arbiter #(.WATCHDOG(WD)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    bit i_rd, d_rd, d_wr;
    logic [15:0] i_addr, d_addr, wdata;
    int lat;
    logic [15:0] rdval;
    bit inj, exp_d, exp_rd, exp_wr;
    logic [15:0] exp_addr;
    int exp_cyc;
    logic [15:0] exp_data;
    bit exp_err;
  } vec_t;
  int total = 0;
  int passed = 0;
  int lat = 0;
  bit err_inj = 1'b0;
  logic [15:0] rdval = 16'h0000;
  bit mbusy = 1'b0;
  int age = 0;
  int cyc = 0;
  int done_cyc = 0;
  bit last_m, err_m;
  logic [15:0] idata_m, ddata_m;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  initial begin
    bus.m_done = 1'b0;
    bus.m_dout = 16'h0000;
    bus.m_err = 1'b0;
    bus.m_stall = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        mbusy = 1'b0;
        age = 0;
      end else if (bus.m_rd || bus.m_wr) begin
        mbusy = 1'b1;
        age = 0;
      end else if (mbusy) age++;
      bus.m_done = mbusy && age == lat;
      bus.m_dout = bus.m_done ? rdval : 16'($urandom);
      bus.m_err = mbusy && err_inj && age == 1;
      bus.m_stall = mbusy && !bus.m_done;
      if (bus.m_done) mbusy = 1'b0;
    end
  end
  task automatic do_reset();
    rst = 1'b0;
    bus.i_rd = 1'b0;
    bus.d_rd = 1'b0;
    bus.d_wr = 1'b0;
    err_inj = 1'b0;
    #1;
    chk("reset outputs", {bus.m_rd, bus.m_wr, bus.err, bus.i_done, bus.d_done, bus.i_data, bus.d_data}, 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    last_m = 1'b0;
    err_m = 1'b0;
    idata_m = 16'h0000;
    ddata_m = 16'h0000;
  endtask
  task automatic do_txn(input bit exp_d, input bit exp_rd, input bit exp_wr, input logic [15:0] exp_addr,
                        input logic [15:0] exp_wdata, input int exp_cyc, input logic [15:0] exp_data,
                        input bit exp_err, input bit withdraw, input string tag);
    int n;
    bit other;
    @(posedge clk);
    #2;
    chk({tag, " strobe"}, {bus.m_rd, bus.m_wr}, {exp_rd, exp_wr});
    chk({tag, " m_addr"}, bus.m_addr, exp_addr);
    if (exp_wr) chk({tag, " m_wdata"}, bus.m_wdata, exp_wdata);
    chk({tag, " stall high"}, exp_d ? bus.d_stall : bus.i_stall, 1);
    if (withdraw) begin
      if (exp_d) {bus.d_rd, bus.d_wr} = 2'b00;
      else bus.i_rd = 1'b0;
    end
    n = 0;
    other = 1'b0;
    while (n < 20) begin
      @(posedge clk);
      #2;
      n++;
      if (exp_d ? bus.i_done : bus.d_done) other = 1'b1;
      if (exp_d ? bus.d_done : bus.i_done) break;
    end
    done_cyc = cyc;
    chk({tag, " latency"}, n, exp_cyc);
    chk({tag, " foreign done"}, other, 0);
    chk({tag, " data"}, exp_d ? bus.d_data : bus.i_data, exp_data);
    chk({tag, " stall low"}, exp_d ? bus.d_stall : bus.i_stall, 0);
    chk({tag, " err"}, bus.err, exp_err);
    @(posedge clk);
    #2;
    chk({tag, " pulse width"}, exp_d ? bus.d_done : bus.i_done, 0);
  endtask
  initial begin
    vec_t vecs[8];
    int t_d;
    bit i_p, d_p, owner, erd, ewr, timed;
    logic [15:0] eaddr, v;
    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'h0000, 3, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0040, 4, 16'h1234, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0100, 16'hBEEF, 0, 16'h5555, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0100, 1, 16'h0000, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0200, 16'h0000, 2, 16'hA5A5, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0200, 3, 16'hA5A5, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0300, 16'h0000, 255, 16'h7777, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0300, 5, 16'h0000, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0310, 16'h0000, 4, 16'h4444, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0310, 5, 16'h4444, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0400, 16'hCAFE, 1, 16'h9999, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0400, 2, 16'h0000, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 16'h0010, 16'h0020, 16'h0000, 1, 16'h1111, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0020, 2, 16'h1111, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 16'h0050, 16'h0000, 16'h0000, 3, 16'h2222, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0050, 4, 16'h2222, 1'b1};
    bus.i_addr = 16'h0000;
    bus.d_addr = 16'h0000;
    bus.d_wdata = 16'h0000;
    #1;
    for (int k = 0; k < 8; k++) begin
      do_reset();
      bus.i_rd = vecs[k].i_rd;
      bus.d_rd = vecs[k].d_rd;
      bus.d_wr = vecs[k].d_wr;
      bus.i_addr = vecs[k].i_addr;
      bus.d_addr = vecs[k].d_addr;
      bus.d_wdata = vecs[k].wdata;
      lat = vecs[k].lat;
      rdval = vecs[k].rdval;
      err_inj = vecs[k].inj;
      do_txn(vecs[k].exp_d, vecs[k].exp_rd, vecs[k].exp_wr, vecs[k].exp_addr, vecs[k].wdata,
             vecs[k].exp_cyc, vecs[k].exp_data, vecs[k].exp_err, 1'b0, $sformatf("vec%0d", k));
    end
    do_reset();
    bus.i_rd = 1'b1;
    bus.i_addr = 16'h00A0;
    bus.d_rd = 1'b1;
    bus.d_addr = 16'h00B0;
    lat = 1;
    rdval = 16'h3333;
    do_txn(1'b1, 1'b1, 1'b0, 16'h00B0, 16'h0000, 2, 16'h3333, 1'b0, 1'b0, "alt1");
    t_d = done_cyc;
    bus.d_addr = 16'h00C0;
    rdval = 16'h4444;
    do_txn(1'b0, 1'b1, 1'b0, 16'h00A0, 16'h0000, 2, 16'h4444, 1'b0, 1'b0, "alt2");
    chk("alt done gap", done_cyc - t_d, 4);
    bus.i_addr = 16'h00D0;
    rdval = 16'h5555;
    do_txn(1'b1, 1'b1, 1'b0, 16'h00C0, 16'h0000, 2, 16'h5555, 1'b0, 1'b0, "alt3");
    do_reset();
    bus.i_rd = 1'b1;
    bus.i_addr = 16'h00E0;
    lat = 2;
    rdval = 16'h6666;
    do_txn(1'b0, 1'b1, 1'b0, 16'h00E0, 16'h0000, 3, 16'h6666, 1'b0, 1'b1, "withdraw");
    do_reset();
    bus.d_rd = 1'b1;
    bus.d_addr = 16'h00F0;
    lat = 255;
    @(posedge clk);
    #2;
    chk("rstwait issue", bus.m_rd, 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rstwait outputs", {bus.m_rd, bus.m_wr, bus.d_done, bus.m_addr}, 0);
    @(posedge clk);
    #2;
    chk("rstwait no done", bus.d_done, 0);
    rst = 1'b1;
    lat = 2;
    rdval = 16'h7A7A;
    do_txn(1'b1, 1'b1, 1'b0, 16'h00F0, 16'h0000, 3, 16'h7A7A, 1'b0, 1'b0, "rstwait redo");
    do_reset();
    i_p = 1'b0;
    d_p = 1'b0;
    for (int r = 0; r < 200; r++) begin
      if (r == 100) begin
        do_reset();
        i_p = 1'b0;
        d_p = 1'b0;
      end
      if (!i_p && $urandom_range(0, 1) == 1) begin
        i_p = 1'b1;
        bus.i_rd = 1'b1;
        bus.i_addr = 16'($urandom);
      end
      if (!d_p && $urandom_range(0, 1) == 1) begin
        int kind;
        kind = $urandom_range(0, 15);
        d_p = 1'b1;
        bus.d_rd = kind < 7 || kind == 15;
        bus.d_wr = kind >= 7;
        bus.d_addr = 16'($urandom);
        bus.d_wdata = 16'($urandom);
      end
      if (!i_p && !d_p) begin
        i_p = 1'b1;
        bus.i_rd = 1'b1;
        bus.i_addr = 16'($urandom);
      end
      owner = (i_p && d_p) ? !last_m : d_p;
      lat = ($urandom_range(0, 7) == 7) ? 255 : int'($urandom_range(0, 5));
      rdval = 16'($urandom);
      err_inj = $urandom_range(0, 15) == 0;
      erd = owner ? !bus.d_wr : 1'b1;
      ewr = owner && bus.d_wr;
      eaddr = owner ? bus.d_addr : bus.i_addr;
      timed = lat > WD;
      if (erd) begin
        v = timed ? 16'h0000 : rdval;
        if (owner) ddata_m = v;
        else idata_m = v;
      end
      err_m = err_m || (owner && bus.d_rd && bus.d_wr) || (err_inj && lat >= 1) || timed;
      last_m = owner;
      do_txn(owner, erd, ewr, eaddr, bus.d_wdata, 1 + (timed ? WD : lat), owner ? ddata_m : idata_m,
             err_m, 1'b0, $sformatf("rnd%0d", r));
      if (owner) begin
        d_p = 1'b0;
        bus.d_rd = 1'b0;
        bus.d_wr = 1'b0;
      end else begin
        i_p = 1'b0;
        bus.i_rd = 1'b0;
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares one multi-cycle memory port (the `mem_system` cache interface: Addr/DataIn/Rd/Wr in, DataOut/Done/Stall/err out) between the fetch stage (instruction reads) and the memory stage (data reads/writes). It serialises requests, sequences each access through issue/wait/complete, returns data and a one-cycle done pulse to the owning requester, and generates the per-stage stall signals (`mStallInstr`, `mStallData`) consumed by the pipeline freeze logic.

## Interface
Parameters:
- `WATCHDOG`, 64: max cycles in WAIT before forced completion; legal 1..255.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_rd`  in  1  fetch read request; held until `i_done`.
- `i_addr`  in  16  fetch address.
- `i_data`  out  16  fetch read data, registered.
- `i_done`  out  1  one-cycle fetch completion pulse.
- `i_stall`  out  1  `i_rd & ~i_done` (drives `mStallInstr`).
- `d_rd`, `d_wr`  in  1 each  data read / write request; held until `d_done`.
- `d_addr`, `d_wdata`  in  16 each  data address / write data.
- `d_data`  out  16  data read data, registered.
- `d_done`  out  1  one-cycle data completion pulse.
- `d_stall`  out  1  `(d_rd|d_wr) & ~d_done` (drives `mStallData`).
- `m_addr`, `m_wdata`  out  16 each  memory address / write data.
- `m_rd`, `m_wr`  out  1 each  memory command strobes.
- `m_dout`  in  16  memory read data, valid with `m_done`.
- `m_done`, `m_stall`, `m_err`  in  1 each  memory completion, busy, error.
- `err`  out  1  sticky error flag.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Registers: state, owner (I/D), last owner, latched addr/wdata/rd/wr, watchdog counter (8 bit), `i_data`, `d_data`, `err`.
- IDLE: sample requests. Only one pending -> grant it. Both pending -> grant the requester that is not `last`. Grant latches address, write data, command, sets owner and `last`, goes to ISSUE. No request -> stay.
- `d_rd & d_wr` both high: treated as write; `err` set.
- ISSUE: `m_rd`/`m_wr` asserted exactly this one cycle from latched command; `m_addr`/`m_wdata` driven from latch in ISSUE and WAIT (0 otherwise). Go to WAIT, or to DONE if `m_done` high this cycle.
- WAIT: strobes low; counter increments each cycle. `m_done` -> DONE. Counter reaches `WATCHDOG` -> DONE with read data forced to 16'h0000, `err` set. `m_stall` is informational only; ignored by the FSM.
- Transition to DONE captures `m_dout` into owner's data register (reads only; writes leave it unchanged). DONE: owner's done pulses; no arbitration; next state IDLE.
- `m_err` high in ISSUE or WAIT sets `err`; transaction still completes normally.
- Requester withdrawing its request mid-transaction (e.g. fetch flush on taken branch): transaction completes, done still pulses, data register still updated; requester ignores it.
- `err` clears only on reset.

## Timing
- Reset (`rst`=0, async): state IDLE, `last`=I, all outputs 0 (`i_data`,`d_data`=16'h0000, `m_rd`,`m_wr`,`err`=0, done pulses 0). Reset mid-transaction drops strobes immediately; access abandoned.
- Request first seen in IDLE at cycle T: strobe at T+1; `m_done` earliest at T+1; done pulse earliest T+2; data valid from done pulse until the next completion for that port.
- Done pulse is registered (cycle after `m_done` edge), exactly one cycle wide.
- Requester advances on the done edge and presents its next request no earlier than the cycle after the done pulse; earliest re-arbitration is the IDLE cycle following DONE. Max throughput: one access per 4 cycles with 1-cycle memory.
- Stall outputs are combinational, low in the done-pulse cycle so the stage advances that edge.
- Simultaneous requests alternate; neither requester waits more than one foreign access.

## Test plan
- Fetch only: `i_rd`=1, `i_addr`=16'h0040, memory `m_done` 3 cycles after strobe with 16'h1234 -> one `m_rd` pulse with `m_addr`=16'h0040, `i_done` one cycle, `i_data`=16'h1234, `i_stall` high until done.
- Simultaneous after reset: `i_rd` and `d_rd` together -> data granted first (`last`=I), fetch next; `i_done` follows `d_done` by ≥3 cycles; third conflict goes to data again.
- Data write: `d_wr`=1, addr 16'h0100, wdata 16'hBEEF, hit same cycle -> single `m_wr`, `d_done` at T+2, `d_data` unchanged.
- Watchdog: `WATCHDOG`=4, memory never asserts `m_done` -> forced DONE after 4 WAIT cycles, `d_data`=16'h0000, `err`=1 stays 1.
- Error and dual command: `m_err` during WAIT -> `err`=1, completion normal; `d_rd`=`d_wr`=1 -> `m_wr` issued, `err`=1.
- Reset mid-WAIT: assert `rst`=0 -> `m_rd`/`m_wr` 0, state IDLE, no done pulse; new request after release completes normally.
